// File: rtl/traffic_intersection_ctrl_pkg.sv
// traffic_pkg: light codes, state encodings and timer width helper
// for the two-road intersection controller (TRAFFIC_PED_WALK_EN adds ped walk).
package traffic_pkg;

    localparam logic [2:0] RED_LIGHT    = 3'b100;
    localparam logic [2:0] YELLOW_LIGHT = 3'b010;
    localparam logic [2:0] GREEN_LIGHT  = 3'b001;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALL_RED_A = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALL_RED_B = 3'd5
    } state_t;

    // Bits needed to hold (largest duration - 1), never less than one.
    function automatic int timer_width(input int a, input int b,
                                       input int c, input int d);
        int m;
        int w;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        w = $clog2(m);
        if (w < 1) w = 1;
        return w;
    endfunction

endpackage

// File: rtl/traffic_intersection_ctrl_if.sv
// Sensor/light bundle between the intersection controller and its environment.
// TRAFFIC_PED_WALK_EN adds ped_req / ped_walk.
interface traffic_intersection_ctrl_if;

    logic       side_sensor;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic [2:0] phase;
    logic       side_pending;
`ifdef TRAFFIC_PED_WALK_EN
    logic       ped_req;
    logic       ped_walk;
`endif

`ifdef TRAFFIC_PED_WALK_EN
    modport slave (
        input  side_sensor, ped_req,
        output ns_light, ew_light, phase, side_pending, ped_walk
    );
    modport master (
        output side_sensor, ped_req,
        input  ns_light, ew_light, phase, side_pending, ped_walk
    );
`else
    modport slave (
        input  side_sensor,
        output ns_light, ew_light, phase, side_pending
    );
    modport master (
        output side_sensor,
        input  ns_light, ew_light, phase, side_pending
    );
`endif

endinterface

// File: rtl/traffic_intersection_ctrl_phase_timer.sv
// phase_timer: loadable down-counter that saturates at zero.
// Shared by every phase of the intersection controller.
module phase_timer #(
    parameter int         W       = 3,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    // Load on phase entry, otherwise count down and park at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= RST_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Two-road intersection sequencer: NS rests green, latched EW demand diverts.
// Define TRAFFIC_PED_WALK_EN to add pedestrian request / walk signal.
module traffic_intersection_ctrl
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN   = 8,
    parameter int SIDE_GREEN  = 6,
    parameter int YELLOW_CYC  = 3,
    parameter int ALL_RED_CYC = 2
) (
    input logic                        clk,
    input logic                        rst,
    traffic_intersection_ctrl_if.slave bus
);

    localparam int W = timer_width(MIN_GREEN, SIDE_GREEN,
                                   YELLOW_CYC, ALL_RED_CYC);

    localparam logic [W-1:0] MG_LD = W'(MIN_GREEN - 1);
    localparam logic [W-1:0] SG_LD = W'(SIDE_GREEN - 1);
    localparam logic [W-1:0] YL_LD = W'(YELLOW_CYC - 1);
    localparam logic [W-1:0] AR_LD = W'(ALL_RED_CYC - 1);

    state_t       state;
    state_t       next_state;
    logic         load;
    logic [W-1:0] load_val;
    logic         zero;
    logic         side_pend;
    logic         request;
    logic         enter_ew;
    logic         in_ew;

`ifdef TRAFFIC_PED_WALK_EN
    logic ped_pend;
    logic walk;
    assign request = side_pend | ped_pend;
`else
    assign request = side_pend;
`endif

    phase_timer #(
        .W       (W),
        .RST_VAL (AR_LD)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .zero     (zero)
    );

    // State register; reset parks in the second all-red clearance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ALL_RED_B;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection and timer reload on every state change.
    always_comb begin
        next_state = state;
        load_val   = AR_LD;
        case (state)
            NS_GREEN:  if (zero && request) next_state = NS_YELLOW;
            NS_YELLOW: if (zero) next_state = ALL_RED_A;
            ALL_RED_A: if (zero) next_state = EW_GREEN;
            EW_GREEN:  if (zero) next_state = EW_YELLOW;
            EW_YELLOW: if (zero) next_state = ALL_RED_B;
            ALL_RED_B: if (zero) next_state = NS_GREEN;
            default:   next_state = ALL_RED_B;
        endcase
        case (next_state)
            NS_GREEN:  load_val = MG_LD;
            NS_YELLOW: load_val = YL_LD;
            ALL_RED_A: load_val = AR_LD;
            EW_GREEN:  load_val = SG_LD;
            EW_YELLOW: load_val = YL_LD;
            default:   load_val = AR_LD;
        endcase
        load = (next_state != state);
    end

    assign in_ew    = (state == EW_GREEN);
    assign enter_ew = (next_state == EW_GREEN) && !in_ew;

    // Side demand latch: clear on EW green entry wins over a new set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            side_pend <= 1'b0;
        end else if (enter_ew) begin
            side_pend <= 1'b0;
        end else if (bus.side_sensor && !in_ew) begin
            side_pend <= 1'b1;
        end
    end

`ifdef TRAFFIC_PED_WALK_EN
    // Pedestrian demand latch, same rules as the side demand.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ped_pend <= 1'b0;
        end else if (enter_ew) begin
            ped_pend <= 1'b0;
        end else if (bus.ped_req && !in_ew) begin
            ped_pend <= 1'b1;
        end
    end

    // Walk lamp follows EW green when a pedestrian asked for it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            walk <= 1'b0;
        end else if (enter_ew) begin
            walk <= ped_pend;
        end else if (in_ew && next_state != EW_GREEN) begin
            walk <= 1'b0;
        end
    end

    assign bus.ped_walk = walk;
`endif

    // Moore light decode; anything unknown shows red both ways.
    always_comb begin
        bus.ns_light = RED_LIGHT;
        bus.ew_light = RED_LIGHT;
        case (state)
            NS_GREEN:  bus.ns_light = GREEN_LIGHT;
            NS_YELLOW: bus.ns_light = YELLOW_LIGHT;
            EW_GREEN:  bus.ew_light = GREEN_LIGHT;
            EW_YELLOW: bus.ew_light = YELLOW_LIGHT;
            default: ;
        endcase
    end

    assign bus.phase        = state;
    assign bus.side_pending = side_pend;

endmodule
